// File: rtl/event_ctl_pkg.sv
// Shared encodings for the event controller: edge_mode values and the mode type.
package event_ctl_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t EDGE_RISE  = 2'b00;
    localparam edge_mode_t EDGE_FALL  = 2'b01;
    localparam edge_mode_t EDGE_BOTH  = 2'b10;
    localparam edge_mode_t EDGE_LEVEL = 2'b11;

endpackage

// File: rtl/event_ctl_if.sv
// Bundle of event inputs, controls and status outputs between the controller and its user.
interface event_ctl_if
    import event_ctl_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 8
);
    logic [N-1:0]     evt_in;
    edge_mode_t       edge_mode;
    logic             en;
    logic             clr;
    logic             x_all;
    logic             y_par;
    logic             x_cap;
    logic             y_cap;
    logic             evt_strobe;
    logic [N-1:0]     evt_vec;
    logic             pend;
    logic [CNT_W-1:0] evt_cnt;
    logic             ovf;

    modport master (
        output evt_in, edge_mode, en, clr,
        input  x_all, y_par, x_cap, y_cap, evt_strobe, evt_vec, pend, evt_cnt, ovf
    );

    modport slave (
        input  evt_in, edge_mode, en, clr,
        output x_all, y_par, x_cap, y_cap, evt_strobe, evt_vec, pend, evt_cnt, ovf
    );
endinterface

// File: rtl/event_ctl_sync.sv
// One event channel: SYNC-deep synchroniser, previous-value register and mode-selected qualifier.
module event_ctl_sync
    import event_ctl_pkg::*;
#(
    parameter int SYNC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       evt_in,
    input  edge_mode_t edge_mode,
    input  logic       qual_en,
    output logic       s,
    output logic       q
);
    logic [SYNC-1:0] chain_reg;
    logic            prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg <= '0;
            prev_reg  <= 1'b0;
        end else begin
            chain_reg[0] <= evt_in;
            for (int k = 1; k < SYNC; k++) begin
                chain_reg[k] <= chain_reg[k-1];
            end
            // prev tracks even when disabled so re-enabling never reports stale edges
            prev_reg <= s;
        end
    end

    assign s = chain_reg[SYNC-1];

    always_comb begin
        q = 1'b0;
        if (qual_en) begin
            unique case (edge_mode)
                EDGE_RISE:  q = s & ~prev_reg;
                EDGE_FALL:  q = ~s & prev_reg;
                EDGE_BOTH:  q = s ^ prev_reg;
                EDGE_LEVEL: q = s;
            endcase
        end
    end
endmodule

// File: rtl/event_ctl_gen.sv
// Event controller top: per-channel qualifiers, reductions, capture registers, saturating counter, flags.
module event_ctl_gen
    import event_ctl_pkg::*;
#(
    parameter int N     = 3,
    parameter int SYNC  = 2,
    parameter int CNT_W = 8
) (
    input logic        clk,
    input logic        rst,
    event_ctl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     s;
    logic [N-1:0]     q;
    logic             any_q;
    logic             qual_en;
    logic             armed_reg;
    logic [N-1:0]     evt_vec_reg;
    logic             evt_strobe_reg;
    logic             x_all_reg;
    logic             y_par_reg;
    logic             x_cap_reg;
    logic             y_cap_reg;
    logic             pend_reg;
    logic [CNT_W-1:0] evt_cnt_reg;
    logic             ovf_reg;

    // Arm flag masks the first cycle so reset values never look like edges
    assign qual_en = armed_reg & bus.en;
    assign any_q   = |q;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            event_ctl_sync #(.SYNC(SYNC)) u_sync (
                .clk       (clk),
                .rst       (rst),
                .evt_in    (bus.evt_in[gi]),
                .edge_mode (bus.edge_mode),
                .qual_en   (qual_en),
                .s         (s[gi]),
                .q         (q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_reg      <= 1'b0;
            evt_vec_reg    <= '0;
            evt_strobe_reg <= 1'b0;
            x_all_reg      <= 1'b0;
            y_par_reg      <= 1'b0;
            x_cap_reg      <= 1'b0;
            y_cap_reg      <= 1'b0;
        end else begin
            armed_reg      <= 1'b1;
            evt_vec_reg    <= q;
            evt_strobe_reg <= any_q;
            x_all_reg      <= &s;
            y_par_reg      <= ~^s;
            if (any_q) begin
                x_cap_reg <= &s;
                y_cap_reg <= ~^s;
            end
        end
    end

    // A strobe in the same cycle as clr restarts the count at one rather than zero
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg    <= 1'b0;
            evt_cnt_reg <= '0;
            ovf_reg     <= 1'b0;
        end else if (any_q) begin
            pend_reg <= 1'b1;
            if (bus.clr) begin
                evt_cnt_reg <= CNT_W'(1);
                ovf_reg     <= 1'b0;
            end else if (evt_cnt_reg == CNT_MAX) begin
                ovf_reg <= 1'b1;
            end else begin
                evt_cnt_reg <= evt_cnt_reg + CNT_W'(1);
            end
        end else if (bus.clr) begin
            pend_reg    <= 1'b0;
            evt_cnt_reg <= '0;
            ovf_reg     <= 1'b0;
        end
    end

    assign bus.evt_vec    = evt_vec_reg;
    assign bus.evt_strobe = evt_strobe_reg;
    assign bus.x_all      = x_all_reg;
    assign bus.y_par      = y_par_reg;
    assign bus.x_cap      = x_cap_reg;
    assign bus.y_cap      = y_cap_reg;
    assign bus.pend       = pend_reg;
    assign bus.evt_cnt    = evt_cnt_reg;
    assign bus.ovf        = ovf_reg;
endmodule
